uart_tx_mmio: RTL

Memory-mapped UART transmitter sitting directly downstream of the Risc32 core's IO bus (`io_address`, `io_write_value`, `io_write_en`, `io_read_en`, `io_read_value`). It accepts byte writes from store instructions into a small FIFO and serialises them as 8N1 frames on a TX pin. It returns status and divisor reads combinationally, so a single-cycle load completes in the same cycle.

---
 rtl/io_map_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_mmio.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// Shared IO-map definitions for Risc32 memory-mapped peripherals:
// register word offsets, STATUS bit layout and the UART TX serialiser states.
package io_map_pkg;

  localparam logic [1:0] UART_DATA_OFS   = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS = 2'd1;
  localparam logic [1:0] UART_DIV_OFS    = 2'd2;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;
  localparam int ST_CNT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_tx_state_t;

  // A zero divisor would stall the baud counter, so it is promoted to 1.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; shared by UART TX and future RX.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the Risc32 IO bus: address decode,
// DIVISOR/STATUS registers, combinational read mux, TX FIFO and serialiser FSM.
module uart_tx_mmio
  import io_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  output logic [31:0] io_read_value,
  output logic        tx
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 sel;
  logic [1:0]           ofs;
  logic                 data_wr;
  logic                 div_wr;
  logic                 status_rd;
  logic                 pop;
  logic                 ovf_set;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [7:0]           fifo_rdata;
  logic [15:0]          divisor;
  logic                 overflow;
  logic [31:0]          status_word;
  uart_tx_state_t       state;
  logic [15:0]          bit_div;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 bit_end;
  logic                 unused_bits;

  assign unused_bits = ^{io_write_value[31:16], io_address[1:0]};

  assign sel       = (io_address[31:4] == BASE_ADDR[31:4]);
  assign ofs       = io_address[3:2];
  assign data_wr   = io_write_en && sel && (ofs == UART_DATA_OFS);
  assign div_wr    = io_write_en && sel && (ofs == UART_DIV_OFS);
  assign status_rd = io_read_en && sel && (ofs == UART_STATUS_OFS);
  assign bit_end   = (baud_cnt == 16'd0);

  // Pop either from IDLE or at the last clock of STOP so frames chain without a gap.
  assign pop     = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign ovf_set = data_wr && fifo_full && !pop;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (pop),
    .wdata (io_write_value[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (div_wr)
        divisor <= clamp_div(io_write_value[15:0]);
      if (ovf_set)
        overflow <= 1'b1;
      else if (status_rd)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[ST_BUSY_BIT]             = (state != S_IDLE);
    status_word[ST_FULL_BIT]             = fifo_full;
    status_word[ST_EMPTY_BIT]            = fifo_empty;
    status_word[ST_OVF_BIT]              = overflow;
    status_word[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    io_read_value = '0;
    if (io_read_en && sel) begin
      case (ofs)
        UART_STATUS_OFS: io_read_value = status_word;
        UART_DIV_OFS:    io_read_value = {16'h0000, divisor};
        default:         io_read_value = '0;
      endcase
    end
  end

  // Data shift register carries no reset; it is always loaded on pop before use.
  always_ff @(posedge clk) begin
    if (pop)
      shreg <= fifo_rdata;
    else if ((state == S_DATA) && bit_end)
      shreg <= {1'b0, shreg[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      bit_div  <= DEFAULT_DIV;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            tx       <= 1'b0;
            bit_div  <= divisor;
            baud_cnt <= divisor - 16'd1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            tx       <= shreg[0];
            baud_cnt <= bit_div - 16'd1;
            bit_cnt  <= 3'd0;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= bit_div - 16'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state    <= S_START;
              tx       <= 1'b0;
              bit_div  <= divisor;
              baud_cnt <= divisor - 16'd1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
